bsh_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter: WIDTH-bit data, log2(WIDTH) registered

---
 rtl/bsh_pkg.sv | 42 ++++
 rtl/bsh_pipe_if.sv | 28 ++
 rtl/bsh_stage.sv | 58 +++++
 rtl/bsh_pipe.sv | 53 +++++
 tb/tb_bsh_pipe.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/bsh_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode codes and the
// single-step shift function used by every pipeline stage.
package bsh_pkg;

    localparam logic [1:0] BSH_LSL = 2'b00;
    localparam logic [1:0] BSH_ASR = 2'b01;
    localparam logic [1:0] BSH_ROT = 2'b10;
    localparam logic [1:0] BSH_RSV = 2'b11;

    // Widest data path the shared step function supports.
    localparam int BSH_MAXW = 64;
    localparam int BSH_IDXW = 6;

    typedef logic [BSH_MAXW-1:0] bsh_word_t;

    // Shift the low 'width' bits of data by 'amt'; upper bits of the result are 0.
    // Reserved mode falls through to logical because only ASR fills and only ROT wraps.
    function automatic bsh_word_t bsh_step(input bsh_word_t data, input int width,
                                           input logic dir, input logic [1:0] mode,
                                           input int amt);
        bsh_word_t r;
        logic      fill;
        int        src;
        r    = '0;
        fill = (dir && mode == BSH_ASR) ? data[BSH_IDXW'(width - 1)] : 1'b0;
        for (int i = 0; i < BSH_MAXW; i++) begin
            if (i < width) begin
                src = dir ? i + amt : i - amt;
                if (mode == BSH_ROT) begin
                    src = (src + width) % width;
                end
                if (src >= 0 && src < width) begin
                    r[i[BSH_IDXW-1:0]] = data[src[BSH_IDXW-1:0]];
                end else begin
                    r[i[BSH_IDXW-1:0]] = fill;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bsh_pipe_if.sv
// Producer/consumer handshake bundle for bsh_pipe: input beat with shift
// controls on one side, shifted result on the other.
interface bsh_pipe_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             dir;
    logic [1:0]       mode;
    logic [SHW-1:0]   sh;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;

    modport master (
        output in_valid, data_in, dir, mode, sh, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, dir, mode, sh, out_ready,
        output in_ready, out_valid, data_out
    );

endinterface

// File: rtl/bsh_stage.sv
// One registered pipeline stage of the barrel shifter: conditionally shifts by
// AMT when its bit of the shift amount is set, with its own valid/advance logic.
module bsh_stage
    import bsh_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int AMT   = 1,
    localparam int SHW   = $clog2(WIDTH),
    localparam int K     = $clog2(AMT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             prev_dir,
    input  logic [1:0]       prev_mode,
    input  logic [SHW-1:0]   prev_sh,
    input  logic             next_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             dir,
    output logic [1:0]       mode,
    output logic [SHW-1:0]   sh
);

    logic [WIDTH-1:0] shifted;

    // An empty stage always loads, so bubbles collapse even under a stall.
    assign ready = ~valid | next_ready;

    always_comb begin
        shifted = prev_data;
        if (prev_sh[K]) begin
            shifted = WIDTH'(bsh_step(bsh_word_t'(prev_data), WIDTH, prev_dir, prev_mode, AMT));
        end
    end

    // Payload only captured with a real beat, so idle stages keep their old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            dir   <= 1'b0;
            mode  <= BSH_LSL;
            sh    <= '0;
        end else if (ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= shifted;
                dir  <= prev_dir;
                mode <= prev_mode;
                sh   <= prev_sh;
            end
        end
    end

endmodule

// File: rtl/bsh_pipe.sv
// Pipelined barrel shifter: log2(WIDTH) registered stages, stage k shifting by
// 2^k, with valid/ready backpressure and one result per cycle.
module bsh_pipe #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    bsh_pipe_if.slave  bus
);

    // Index 0 is the input port; index k+1 is the output of stage k.
    logic [SHW:0]     v;
    logic [SHW:0]     rdy;
    logic [WIDTH-1:0] d  [SHW+1];
    logic             dr [SHW+1];
    logic [1:0]       md [SHW+1];
    logic [SHW-1:0]   s  [SHW+1];

    assign v[0]     = bus.in_valid;
    assign d[0]     = bus.data_in;
    assign dr[0]    = bus.dir;
    assign md[0]    = bus.mode;
    assign s[0]     = bus.sh;
    assign rdy[SHW] = bus.out_ready;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        bsh_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .prev_valid (v[k]),
            .prev_data  (d[k]),
            .prev_dir   (dr[k]),
            .prev_mode  (md[k]),
            .prev_sh    (s[k]),
            .next_ready (rdy[k+1]),
            .ready      (rdy[k]),
            .valid      (v[k+1]),
            .data       (d[k+1]),
            .dir        (dr[k+1]),
            .mode       (md[k+1]),
            .sh         (s[k+1])
        );
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v[SHW];
    assign bus.data_out  = d[SHW];

endmodule

// File: tb/tb_bsh_pipe.sv
// Directed and streaming checks of bsh_pipe at WIDTH=32, plus a WIDTH=8
// instance for the narrow arithmetic-shift case.
module tb_bsh_pipe;
    import bsh_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bsh_pipe_if #(.WIDTH(32)) bus32 ();
    bsh_pipe_if #(.WIDTH(8))  bus8  ();

    bsh_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    bsh_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    int assert_count = 0;
    int fail_count   = 0;

    logic [31:0] exp_q [$];

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit narrow, input logic valid, input logic [31:0] d,
                                 input logic dr, input logic [1:0] md, input logic [4:0] s);
        if (narrow) begin
            bus8.in_valid = valid;
            bus8.data_in  = d[7:0];
            bus8.dir      = dr;
            bus8.mode     = md;
            bus8.sh       = s[2:0];
        end else begin
            bus32.in_valid = valid;
            bus32.data_in  = d;
            bus32.dir      = dr;
            bus32.mode     = md;
            bus32.sh       = s;
        end
    endtask

    // Latency counts edges from the accepting edge (inclusive) up to the one
    // after which out_valid is first seen.
    task automatic runBeat(input string tag, input bit narrow, input logic [31:0] d,
                           input logic dr, input logic [1:0] md, input logic [4:0] s,
                           input logic [31:0] expected, input int exp_lat);
        int lat;
        @(negedge clk);
        bus32.out_ready = 1'b1;
        bus8.out_ready  = 1'b1;
        applyStimulus(narrow, 1'b1, d, dr, md, s);
        #1;
        checkOutput({tag, " in_ready"}, 64'(narrow ? bus8.in_ready : bus32.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(narrow, 1'b0, 32'd0, 1'b0, BSH_LSL, 5'd0);
        lat = 1;
        while (!(narrow ? bus8.out_valid : bus32.out_valid) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, " data"}, narrow ? 64'(bus8.data_out) : 64'(bus32.data_out),
                    64'(expected));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] cur_d;
        logic        cur_dir;
        logic [1:0]  cur_mode;
        logic [4:0]  cur_sh;
        logic [31:0] prev_data;
        logic        prev_stall;
        logic        emit;
        logic        accept;
        int          sent;
        int          recv;
        int          in_flight;
        int          cycles;
        int          ghosts;

        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, BSH_LSL, 5'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, BSH_LSL, 5'd0);
        bus32.out_ready = 1'b1;
        bus8.out_ready  = 1'b1;

        // Reset state while asserted and in the first cycle after release.
        #3;
        checkOutput("reset out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("reset data_out", 64'(bus32.data_out), 64'd0);
        checkOutput("reset in_ready", 64'(bus32.in_ready), 64'd1);
        checkOutput("reset w8 out_valid", 64'(bus8.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("post-reset in_ready", 64'(bus32.in_ready), 64'd1);

        // Directed vectors with hand-computed results.
        runBeat("lsl 1<<31",    1'b0, 32'h0000_0001, 1'b0, BSH_LSL, 5'd31, 32'h8000_0000, 5);
        runBeat("asr >>4",      1'b0, 32'h8000_00F0, 1'b1, BSH_ASR, 5'd4,  32'hF800_000F, 5);
        runBeat("lsr >>4",      1'b0, 32'h8000_00F0, 1'b1, BSH_LSL, 5'd4,  32'h0800_000F, 5);
        runBeat("rsv >>4",      1'b0, 32'h8000_00F0, 1'b1, BSH_RSV, 5'd4,  32'h0800_000F, 5);
        runBeat("rol 8",        1'b0, 32'h1234_5678, 1'b0, BSH_ROT, 5'd8,  32'h3456_7812, 5);
        runBeat("ror 8",        1'b0, 32'h1234_5678, 1'b1, BSH_ROT, 5'd8,  32'h7812_3456, 5);
        runBeat("rot sh0",      1'b0, 32'h1234_5678, 1'b1, BSH_ROT, 5'd0,  32'h1234_5678, 5);
        runBeat("asr left",     1'b0, 32'hC000_0003, 1'b0, BSH_ASR, 5'd1,  32'h8000_0006, 5);
        runBeat("ror 1 wrap",   1'b0, 32'h0000_0001, 1'b1, BSH_ROT, 5'd1,  32'h8000_0000, 5);
        runBeat("asr >>31",     1'b0, 32'h8000_0000, 1'b1, BSH_ASR, 5'd31, 32'hFFFF_FFFF, 5);
        runBeat("asr sh0",      1'b0, 32'h8765_4321, 1'b1, BSH_ASR, 5'd0,  32'h8765_4321, 5);

        // Narrow instance.
        runBeat("w8 asr >>7",   1'b1, 32'h0000_00B4, 1'b1, BSH_ASR, 5'd7,  32'h0000_00FF, 3);
        runBeat("w8 rol 3",     1'b1, 32'h0000_00B4, 1'b0, BSH_ROT, 5'd3,  32'h0000_00A5, 3);

        // Back-to-back stream under random backpressure.
        sent       = 0;
        recv       = 0;
        in_flight  = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        cur_d      = $urandom;
        cur_dir    = 1'($urandom_range(0, 1));
        cur_mode   = 2'($urandom_range(0, 3));
        cur_sh     = 5'($urandom_range(0, 31));
        while ((sent < 20 || recv < 20) && cycles < 600) begin
            @(negedge clk);
            cycles++;
            if (prev_stall) begin
                checkOutput("stall out_valid", 64'(bus32.out_valid), 64'd1);
                checkOutput("stall data_out", 64'(bus32.data_out), 64'(prev_data));
            end
            bus32.out_ready = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, sent < 20, cur_d, cur_dir, cur_mode, cur_sh);
            #1;
            checkOutput("stream in_ready", 64'(bus32.in_ready),
                        64'(!(in_flight == 5 && !bus32.out_ready)));
            emit   = bus32.out_valid & bus32.out_ready;
            accept = bus32.in_valid & bus32.in_ready;
            if (emit) begin
                checkOutput("stream beat expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    checkOutput("stream data", 64'(bus32.data_out), 64'(exp_q.pop_front()));
                end
                recv++;
            end
            if (accept) begin
                exp_q.push_back(32'(bsh_step(64'(cur_d), 32, cur_dir, cur_mode, int'(cur_sh))));
                sent++;
                cur_d    = $urandom;
                cur_dir  = 1'($urandom_range(0, 1));
                cur_mode = 2'($urandom_range(0, 3));
                cur_sh   = 5'($urandom_range(0, 31));
            end
            in_flight  = in_flight + int'(accept) - int'(emit);
            prev_stall = bus32.out_valid & ~bus32.out_ready;
            prev_data  = bus32.data_out;
        end
        checkOutput("stream received", 64'(recv), 64'd20);
        checkOutput("stream leftover", 64'(exp_q.size()), 64'd0);

        // Fill the pipeline while stalled, then reset mid-cycle.
        @(negedge clk);
        bus32.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h1111_1111 * (i + 1), 1'b0, BSH_LSL, 5'd1);
            #1;
            checkOutput("fill in_ready", 64'(bus32.in_ready), 64'd1);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, BSH_LSL, 5'd0);
        #1;
        checkOutput("full in_ready", 64'(bus32.in_ready), 64'd0);
        checkOutput("full out_valid", 64'(bus32.out_valid), 64'd1);
        checkOutput("full head data", 64'(bus32.data_out), 64'h2222_2222);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("async rst data_out", 64'(bus32.data_out), 64'd0);
        checkOutput("async rst in_ready", 64'(bus32.in_ready), 64'd1);
        #9;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("after rst out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("after rst data_out", 64'(bus32.data_out), 64'd0);
        checkOutput("after rst in_ready", 64'(bus32.in_ready), 64'd1);
        bus32.out_ready = 1'b1;
        ghosts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus32.out_valid) ghosts++;
        end
        checkOutput("no ghost beats", 64'(ghosts), 64'd0);
        runBeat("after rst beat", 1'b0, 32'h0000_00F0, 1'b1, BSH_LSL, 5'd4, 32'h0000_000F, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
